mc_control: RTL and testbench
=============================

# mc_control

Multicycle main controller that sequences every instruction through fetch, decode, execute, memory and writeback. It decodes opcode and funct into per-cycle datapath controls, including the 3-bit `aluc` consumed directly by the downstream ALU, and uses the ALU's `zero` flag to resolve branches. Supported instructions:

- R-type: add, sub, or, sll
- I-type: lw, sw, beq, addi, ori
- J-type: j

## Interface
- No parameters; all encodings are package constants.
- `clk` in 1 — sole clock, rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `op` in 6 — IR[31:26].
- `funct` in 6 — IR[5:0].
- `zero` in 1 — ALU zero flag, same cycle.
- `pc_en` out 1 — PC load enable: `pc_write | (branch & zero)`.
- `iord` out 1 — memory address select: 0 = PC, 1 = ALUOut.
- `mem_write` out 1 — memory write strobe.
- `ir_write` out 1 — IR load enable.
- `reg_dst` out 1 — write register select: 0 = rt, 1 = rd.
- `mem_to_reg` out 1 — write data select: 0 = ALUOut, 1 = MDR.
- `reg_write` out 1 — register file write enable.
- `alu_src_a` out 2 — ALU A select: 00 = PC, 01 = rs data, 10 = zero-extended shamt.
- `alu_src_b` out 2 — ALU B select: 00 = rt data, 01 = const 4, 10 = ext imm, 11 = sign-ext imm<<2.
- `ext_sel` out 1 — immediate extension: 0 = sign, 1 = zero.
- `pc_src` out 2 — PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `aluc` out 3 — ALU op: 000 add, 001 sub, 010 or, 011 sll (b << a[4:0]).
- `halted` out 1 — illegal-instruction halt flag (see Configuration).
- `state` out 4 — current state, debug only.

## Operation
- Moore FSM with a 4-bit state register. All outputs are decoded from state, op and funct. Any output not listed for a state is 0.
- **FETCH(0):** `ir_write`=1, `pc_write`=1, `alu_src_a`=00, `alu_src_b`=01, `aluc`=000, `pc_src`=00. Next state DECODE.
- **DECODE(1):** `alu_src_a`=00, `alu_src_b`=11, `aluc`=000 (branch target into ALUOut). Next state by op:
  - lw/sw → MEMADR
  - R-type (000000) → EXEC
  - beq (000100) → BRANCH
  - addi (001000) / ori (001101) → IEXEC
  - j (000010) → JUMP
  - anything else → ILLEGAL handling
- **MEMADR(2):** `alu_src_a`=01, `alu_src_b`=10, `ext_sel`=0, `aluc`=000. Next: lw (100011) → MEMRD, sw (101011) → MEMWR.
- **MEMRD(3):** `iord`=1. Next MEMWB.
- **MEMWB(4):** `reg_dst`=0, `mem_to_reg`=1, `reg_write`=1. Next FETCH.
- **MEMWR(5):** `iord`=1, `mem_write`=1. Next FETCH.
- **EXEC(6):** `alu_src_b`=00, `aluc` set by funct:
  - 100000 → 000
  - 100010 → 001
  - 100101 → 010
  - 000000 → 011, with `alu_src_a`=10
  - For add/sub/or, `alu_src_a`=01.
  - Unknown funct → ILLEGAL handling; no writeback.
  - Next ALUWB.
- **ALUWB(7):** `reg_dst`=1, `mem_to_reg`=0, `reg_write`=1. Next FETCH.
- **BRANCH(8):** `alu_src_a`=01, `alu_src_b`=00, `aluc`=001, `branch`=1, `pc_src`=01. Next FETCH.
- **IEXEC(9):** `alu_src_a`=01, `alu_src_b`=10. addi: `aluc`=000, `ext_sel`=0. ori: `aluc`=010, `ext_sel`=1. Next IWB.
- **IWB(10):** `reg_dst`=0, `mem_to_reg`=0, `reg_write`=1. Next FETCH.
- **JUMP(11):** `pc_write`=1, `pc_src`=10. Next FETCH.
- **HALT(12):** all enables 0. Stays in HALT until reset.
- Unused encodings 13–15 go to FETCH on the next edge with all enables 0.

## Timing
- CPI: lw 5, sw 4, R-type 4, addi/ori 4, beq 3, j 3.
- `pc_en` in BRANCH is combinational on the same-cycle `zero`; there is no register between `zero` and `pc_en`.
- While `rst`=1: `pc_en`, `ir_write`, `mem_write` and `reg_write` are forced to 0 combinationally. The next edge loads state=FETCH and clears `halted`.
- After reset release, the first edge performs FETCH.
- Reset asserted mid-instruction aborts the instruction; no write strobe fires in the reset cycle.
- `op` and `funct` are stable from DECODE through the last state of the instruction, because `ir_write` is asserted only in FETCH.

## Configuration
- `MC_CTRL_ILLEGAL_HALT_EN` defined:
  - An unknown op in DECODE, or unknown funct in EXEC, goes to HALT.
  - `halted`=1 from the following cycle until reset.
- Undefined:
  - Illegal instructions go to FETCH (executed as NOP; PC already advanced).
  - `halted` tied 0.
  - The HALT state is unreachable.

## Structure
- Package `mc_pkg` holds:
  - state enum/localparams (4 bits)
  - opcode and funct constants
  - `aluc` codes (ADD/SUB/OR/SLL)
  - `alu_src_a`, `alu_src_b` and `pc_src` select constants
- Sub-module `mc_alu_dec`: combinational (state-class, op, funct) → `aluc`, `alu_src_a` override, `ext_sel`, `illegal_funct`.

## Test plan
- **Reset then lw** (op=100011): state sequence 0,1,2,3,4,0. `ir_write`=1 only in cycle 1. `reg_write`=1 with `mem_to_reg`=1 only in cycle 5.
- **R-type sll** (op=0, funct=000000): in EXEC, `aluc`=011 and `alu_src_a`=10. ALUWB: `reg_dst`=1, `reg_write`=1. 4 cycles total.
- **beq** with `zero`=1 → `pc_en`=1 and `pc_src`=01 in BRANCH. Repeat with `zero`=0 → `pc_en`=0. Both return to FETCH after 3 cycles.
- **ori** (op=001101): IEXEC drives `aluc`=010, `ext_sel`=1, `alu_src_b`=10. IWB asserts `reg_write`=1 with `reg_dst`=0.
- **Illegal op** 111111:
  - Macro defined: state goes to 12 and `halted`=1; both hold for 10 cycles; `rst` pulse returns to state 0.
  - Macro undefined: returns to FETCH after DECODE.
- **`rst`=1 asserted during MEMWR**: `mem_write`=0 in that cycle, and state=0 after the edge.

Source files
------------

// File: rtl/mc_pkg.sv
// mc_pkg: shared encodings for the multicycle main controller.
// Contents: FSM state enum (4-bit, debug-visible values), ALU decode class,
// opcode/funct constants, aluc codes and datapath mux select constants.
// Optional feature macro used by consumers: MC_CTRL_ILLEGAL_HALT_EN.
package mc_pkg;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_EXEC   = 4'd6,
    ST_ALUWB  = 4'd7,
    ST_BRANCH = 4'd8,
    ST_IEXEC  = 4'd9,
    ST_IWB    = 4'd10,
    ST_JUMP   = 4'd11,
    ST_HALT   = 4'd12
  } state_e;

  // Which rule the ALU decoder applies in the current state.
  typedef enum logic [1:0] {
    CLS_ADD   = 2'd0,  // address / PC arithmetic: plain add, sign-extend
    CLS_SUB   = 2'd1,  // beq compare
    CLS_RTYPE = 2'd2,  // operation chosen by funct
    CLS_ITYPE = 2'd3   // operation chosen by op (addi / ori)
  } alu_cls_e;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_OR  = 6'b100101;

  // ALU operation codes
  localparam logic [2:0] ALUC_ADD = 3'b000;
  localparam logic [2:0] ALUC_SUB = 3'b001;
  localparam logic [2:0] ALUC_OR  = 3'b010;
  localparam logic [2:0] ALUC_SLL = 3'b011;

  // ALU A select
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_RS    = 2'b01;
  localparam logic [1:0] SRCA_SHAMT = 2'b10;

  // ALU B select
  localparam logic [1:0] SRCB_RT   = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// mc_alu_dec: combinational ALU control decoder.
// Ports:
//   cls_i           - decode class of the current FSM state
//   op_i, funct_i   - instruction fields
//   aluc_o          - 3-bit ALU operation
//   src_a_shamt_o   - request ALU A = zero-extended shamt (sll)
//   ext_sel_o       - immediate extension: 0 sign, 1 zero
//   illegal_funct_o - R-type funct not supported
module mc_alu_dec
  import mc_pkg::*;
(
  input  alu_cls_e   cls_i,
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output logic [2:0] aluc_o,
  output logic       src_a_shamt_o,
  output logic       ext_sel_o,
  output logic       illegal_funct_o
);

  always_comb begin
    aluc_o          = ALUC_ADD;
    src_a_shamt_o   = 1'b0;
    ext_sel_o       = 1'b0;
    illegal_funct_o = 1'b0;
    unique case (cls_i)
      CLS_ADD: ;
      CLS_SUB: aluc_o = ALUC_SUB;
      CLS_RTYPE: begin
        unique case (funct_i)
          FN_ADD: aluc_o = ALUC_ADD;
          FN_SUB: aluc_o = ALUC_SUB;
          FN_OR:  aluc_o = ALUC_OR;
          FN_SLL: begin
            aluc_o        = ALUC_SLL;
            src_a_shamt_o = 1'b1;
          end
          default: illegal_funct_o = 1'b1;
        endcase
      end
      CLS_ITYPE: begin
        if (op_i == OP_ORI) begin
          aluc_o    = ALUC_OR;
          ext_sel_o = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// mc_control: multicycle main controller (Moore FSM).
// Sequences fetch/decode/execute/memory/writeback for add, sub, or, sll,
// lw, sw, beq, addi, ori, j.
// Ports:
//   clk, rst      - clock (rising edge), synchronous active-high reset
//   op, funct     - IR[31:26], IR[5:0]
//   zero          - ALU zero flag, used same cycle for beq
//   pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
//   alu_src_a, alu_src_b, ext_sel, pc_src, aluc - datapath controls
//   halted        - illegal-instruction halt flag
//   state         - current FSM state (debug)
// Optional feature: MC_CTRL_ILLEGAL_HALT_EN - illegal op/funct parks the
// FSM in HALT with halted=1 until reset; otherwise illegal instructions
// complete as NOPs and halted is tied low.
module mc_control
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_sel,
  output logic [1:0] pc_src,
  output logic [2:0] aluc,
  output logic       halted,
  output logic [3:0] state
);

`ifdef MC_CTRL_ILLEGAL_HALT_EN
  localparam state_e ST_ILLEGAL = ST_HALT;
`else
  localparam state_e ST_ILLEGAL = ST_FETCH;
`endif

  state_e     state_q, state_d;
  alu_cls_e   alu_cls;
  logic       pc_write_c, branch_c;
  logic       mem_write_c, ir_write_c, reg_write_c;
  logic       dec_shamt, illegal_funct;

  mc_alu_dec u_alu_dec (
    .cls_i           (alu_cls),
    .op_i            (op),
    .funct_i         (funct),
    .aluc_o          (aluc),
    .src_a_shamt_o   (dec_shamt),
    .ext_sel_o       (ext_sel),
    .illegal_funct_o (illegal_funct)
  );

  always_comb begin
    alu_cls = CLS_ADD;
    unique case (state_q)
      ST_BRANCH: alu_cls = CLS_SUB;
      ST_EXEC:   alu_cls = CLS_RTYPE;
      ST_IEXEC:  alu_cls = CLS_ITYPE;
      default:   alu_cls = CLS_ADD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    pc_write_c  = 1'b0;
    branch_c    = 1'b0;
    iord        = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write_c = 1'b0;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RT;
    pc_src      = PCSRC_ALU;
    unique case (state_q)
      ST_FETCH: begin
        ir_write_c = 1'b1;
        pc_write_c = 1'b1;
        alu_src_b  = SRCB_FOUR;
        state_d    = ST_DECODE;
      end
      ST_DECODE: begin
        // Branch target is computed speculatively into ALUOut here.
        alu_src_b = SRCB_BOFF;
        if (is_mem_op(op)) begin
          state_d = ST_MEMADR;
        end else begin
          unique case (op)
            OP_RTYPE:        state_d = ST_EXEC;
            OP_BEQ:          state_d = ST_BRANCH;
            OP_ADDI, OP_ORI: state_d = ST_IEXEC;
            OP_J:            state_d = ST_JUMP;
            default:         state_d = ST_ILLEGAL;
          endcase
        end
      end
      ST_MEMADR: begin
        alu_src_a = SRCA_RS;
        alu_src_b = SRCB_IMM;
        state_d   = (op == OP_LW) ? ST_MEMRD : ST_MEMWR;
      end
      ST_MEMRD: begin
        iord    = 1'b1;
        state_d = ST_MEMWB;
      end
      ST_MEMWB: begin
        mem_to_reg  = 1'b1;
        reg_write_c = 1'b1;
        state_d     = ST_FETCH;
      end
      ST_MEMWR: begin
        iord        = 1'b1;
        mem_write_c = 1'b1;
        state_d     = ST_FETCH;
      end
      ST_EXEC: begin
        alu_src_a = dec_shamt ? SRCA_SHAMT : SRCA_RS;
        alu_src_b = SRCB_RT;
        // Unknown funct skips ALUWB so nothing is written back.
        state_d   = illegal_funct ? ST_ILLEGAL : ST_ALUWB;
      end
      ST_ALUWB: begin
        reg_dst     = 1'b1;
        reg_write_c = 1'b1;
        state_d     = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_src_a = SRCA_RS;
        alu_src_b = SRCB_RT;
        branch_c  = 1'b1;
        pc_src    = PCSRC_ALUOUT;
        state_d   = ST_FETCH;
      end
      ST_IEXEC: begin
        alu_src_a = SRCA_RS;
        alu_src_b = SRCB_IMM;
        state_d   = ST_IWB;
      end
      ST_IWB: begin
        reg_write_c = 1'b1;
        state_d     = ST_FETCH;
      end
      ST_JUMP: begin
        pc_write_c = 1'b1;
        pc_src     = PCSRC_JUMP;
        state_d    = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  // Write strobes are masked combinationally so a reset cycle never commits.
  assign pc_en     = ~rst & (pc_write_c | (branch_c & zero));
  assign ir_write  = ~rst & ir_write_c;
  assign mem_write = ~rst & mem_write_c;
  assign reg_write = ~rst & reg_write_c;
  assign state     = state_q;

`ifdef MC_CTRL_ILLEGAL_HALT_EN
  logic halted_q;
  always_ff @(posedge clk) begin
    if (rst)                      halted_q <= 1'b0;
    else if (state_d == ST_HALT)  halted_q <= 1'b1;
  end
  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: scoreboard bench for mc_control. Each stimulus cycle pushes
// the expected state and control word; a checker pops and compares them
// shortly after the falling edge.
module tb_mc_control;

  typedef struct packed {
    logic       pe, io, mw, irw, rd, m2r, rw;
    logic [1:0] sa, sbs;
    logic       ext;
    logic [1:0] ps;
    logic [2:0] al;
    logic       h;
  } ctl_t;

  typedef struct packed {
    logic [3:0] st;
    ctl_t       c;
    logic       chk;
  } exp_t;

  logic       clk, rst, zero;
  logic [5:0] op, funct;
  logic       pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic [1:0] alu_src_a, alu_src_b, pc_src;
  logic       ext_sel, halted;
  logic [2:0] aluc;
  logic [3:0] state;

  mc_control dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
    .pc_en(pc_en), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_sel(ext_sel),
    .pc_src(pc_src), .aluc(aluc), .halted(halted), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ctl_t obs;
  assign obs = {pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                alu_src_a, alu_src_b, ext_sel, pc_src, aluc, halted};

  exp_t       sb[$];
  exp_t       cur;
  int         n_cmp = 0;
  int         n_err = 0;
  int         n_pop = 0;
  logic [5:0] nxt_op = '0;
  logic [5:0] nxt_fn = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic ctl_t mk(input logic pe, io, mw, irw, rd, m2r, rw,
                              input logic [1:0] sa, sbs, input logic ext,
                              input logic [1:0] ps, input logic [2:0] al,
                              input logic h);
    ctl_t c;
    c = {pe, io, mw, irw, rd, m2r, rw, sa, sbs, ext, ps, al, h};
    return c;
  endfunction

  // Checker: compares one expected entry per cycle, 2 time units after negedge.
  always begin
    @(negedge clk);
    #2;
    if (sb.size() != 0) begin
      cur = sb.pop_front();
      n_pop++;
      check_eq($sformatf("state[%0d]", n_pop), {28'd0, state}, {28'd0, cur.st});
      if (cur.chk)
        check_eq($sformatf("ctl[%0d]", n_pop), {14'd0, obs}, {14'd0, cur.c});
    end
  end

  task automatic set_ir(input logic [5:0] o, input logic [5:0] f);
    nxt_op = o;
    nxt_fn = f;
  endtask

  task automatic cyc(input logic r, input logic z, input logic [3:0] st,
                     input ctl_t c, input logic chk = 1'b1);
    exp_t e;
    @(negedge clk);
    rst   = r;
    zero  = z;
    op    = nxt_op;
    funct = nxt_fn;
    e.st  = st;
    e.c   = c;
    e.chk = chk;
    sb.push_back(e);
  endtask

  ctl_t RST_C, FETCH_C, DEC_C, MADR_C, MRD_C, MWB_C, MWR_C, MWR_RST_C;
  ctl_t EX_ADD, EX_SUB, EX_OR, EX_SLL, AWB_C, BR_T, BR_N;
  ctl_t IEX_ADDI, IEX_ORI, IWB_C, JMP_C, HALT_C;

  initial begin
    RST_C     = mk(0,0,0,0,0,0,0, 2'b00,2'b01, 0, 2'b00, 3'b000, 0);
    FETCH_C   = mk(1,0,0,1,0,0,0, 2'b00,2'b01, 0, 2'b00, 3'b000, 0);
    DEC_C     = mk(0,0,0,0,0,0,0, 2'b00,2'b11, 0, 2'b00, 3'b000, 0);
    MADR_C    = mk(0,0,0,0,0,0,0, 2'b01,2'b10, 0, 2'b00, 3'b000, 0);
    MRD_C     = mk(0,1,0,0,0,0,0, 2'b00,2'b00, 0, 2'b00, 3'b000, 0);
    MWB_C     = mk(0,0,0,0,0,1,1, 2'b00,2'b00, 0, 2'b00, 3'b000, 0);
    MWR_C     = mk(0,1,1,0,0,0,0, 2'b00,2'b00, 0, 2'b00, 3'b000, 0);
    MWR_RST_C = mk(0,1,0,0,0,0,0, 2'b00,2'b00, 0, 2'b00, 3'b000, 0);
    EX_ADD    = mk(0,0,0,0,0,0,0, 2'b01,2'b00, 0, 2'b00, 3'b000, 0);
    EX_SUB    = mk(0,0,0,0,0,0,0, 2'b01,2'b00, 0, 2'b00, 3'b001, 0);
    EX_OR     = mk(0,0,0,0,0,0,0, 2'b01,2'b00, 0, 2'b00, 3'b010, 0);
    EX_SLL    = mk(0,0,0,0,0,0,0, 2'b10,2'b00, 0, 2'b00, 3'b011, 0);
    AWB_C     = mk(0,0,0,0,1,0,1, 2'b00,2'b00, 0, 2'b00, 3'b000, 0);
    BR_T      = mk(1,0,0,0,0,0,0, 2'b01,2'b00, 0, 2'b01, 3'b001, 0);
    BR_N      = mk(0,0,0,0,0,0,0, 2'b01,2'b00, 0, 2'b01, 3'b001, 0);
    IEX_ADDI  = mk(0,0,0,0,0,0,0, 2'b01,2'b10, 0, 2'b00, 3'b000, 0);
    IEX_ORI   = mk(0,0,0,0,0,0,0, 2'b01,2'b10, 1, 2'b00, 3'b010, 0);
    IWB_C     = mk(0,0,0,0,0,0,1, 2'b00,2'b00, 0, 2'b00, 3'b000, 0);
    JMP_C     = mk(1,0,0,0,0,0,0, 2'b00,2'b00, 0, 2'b10, 3'b000, 0);
    HALT_C    = mk(0,0,0,0,0,0,0, 2'b00,2'b00, 0, 2'b00, 3'b000, 1);

    rst = 1'b1; zero = 1'b0; op = '0; funct = '0;

    // Reset state: FETCH with all strobes masked.
    cyc(1, 0, 4'd0, RST_C);

    // lw: 0,1,2,3,4 then FETCH of the next instruction.
    set_ir(6'b100011, 6'b000000);
    cyc(0,0,4'd0,FETCH_C); cyc(0,0,4'd1,DEC_C); cyc(0,0,4'd2,MADR_C);
    cyc(0,0,4'd3,MRD_C);   cyc(0,0,4'd4,MWB_C);

    // R-type: sll, add, sub, or.
    set_ir(6'b000000, 6'b000000);
    cyc(0,0,4'd0,FETCH_C); cyc(0,0,4'd1,DEC_C); cyc(0,0,4'd6,EX_SLL); cyc(0,0,4'd7,AWB_C);
    set_ir(6'b000000, 6'b100000);
    cyc(0,0,4'd0,FETCH_C); cyc(0,0,4'd1,DEC_C); cyc(0,0,4'd6,EX_ADD); cyc(0,0,4'd7,AWB_C);
    set_ir(6'b000000, 6'b100010);
    cyc(0,0,4'd0,FETCH_C); cyc(0,0,4'd1,DEC_C); cyc(0,0,4'd6,EX_SUB); cyc(0,0,4'd7,AWB_C);
    set_ir(6'b000000, 6'b100101);
    cyc(0,0,4'd0,FETCH_C); cyc(0,0,4'd1,DEC_C); cyc(0,0,4'd6,EX_OR);  cyc(0,0,4'd7,AWB_C);

    // beq taken / not taken.
    set_ir(6'b000100, 6'b000000);
    cyc(0,1,4'd0,FETCH_C); cyc(0,1,4'd1,DEC_C); cyc(0,1,4'd8,BR_T);
    cyc(0,0,4'd0,FETCH_C); cyc(0,0,4'd1,DEC_C); cyc(0,0,4'd8,BR_N);

    // ori, addi.
    set_ir(6'b001101, 6'b000000);
    cyc(0,0,4'd0,FETCH_C); cyc(0,0,4'd1,DEC_C); cyc(0,0,4'd9,IEX_ORI);  cyc(0,0,4'd10,IWB_C);
    set_ir(6'b001000, 6'b000000);
    cyc(0,0,4'd0,FETCH_C); cyc(0,0,4'd1,DEC_C); cyc(0,0,4'd9,IEX_ADDI); cyc(0,0,4'd10,IWB_C);

    // sw, j.
    set_ir(6'b101011, 6'b000000);
    cyc(0,0,4'd0,FETCH_C); cyc(0,0,4'd1,DEC_C); cyc(0,0,4'd2,MADR_C); cyc(0,0,4'd5,MWR_C);
    set_ir(6'b000010, 6'b000000);
    cyc(0,0,4'd0,FETCH_C); cyc(0,0,4'd1,DEC_C); cyc(0,0,4'd11,JMP_C);

    // sw aborted by reset in MEMWR.
    set_ir(6'b101011, 6'b000000);
    cyc(0,0,4'd0,FETCH_C); cyc(0,0,4'd1,DEC_C); cyc(0,0,4'd2,MADR_C);
    cyc(1,0,4'd5,MWR_RST_C);
    cyc(1,0,4'd0,RST_C);

    // Unknown funct in EXEC (controls there are unspecified).
    set_ir(6'b000000, 6'b111111);
    cyc(0,0,4'd0,FETCH_C); cyc(0,0,4'd1,DEC_C); cyc(0,0,4'd6,EX_ADD,1'b0);
`ifdef MC_CTRL_ILLEGAL_HALT_EN
    cyc(0,0,4'd12,HALT_C);
    cyc(1,0,4'd12,HALT_C);
    cyc(1,0,4'd0,RST_C);
`endif

    // Unknown opcode.
    set_ir(6'b111111, 6'b000000);
    cyc(0,0,4'd0,FETCH_C); cyc(0,0,4'd1,DEC_C);
`ifdef MC_CTRL_ILLEGAL_HALT_EN
    for (int i = 0; i < 10; i++) cyc(0,0,4'd12,HALT_C);
    cyc(1,0,4'd12,HALT_C);
    cyc(1,0,4'd0,RST_C);
`endif

    // Normal operation resumes.
    set_ir(6'b000010, 6'b000000);
    cyc(0,0,4'd0,FETCH_C); cyc(0,0,4'd1,DEC_C); cyc(0,0,4'd11,JMP_C);
    cyc(0,0,4'd0,FETCH_C);

    @(negedge clk);
    #4;
    check_eq("sb_drain", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
